uart_rx_oversample: RTL and testbench

UART receive engine that consumes the serial rx_in line and produces the byte-wide rx_data/rx_empty/uld_rx_data holding-register interface. It is the downstream consumer of the serial line in the UART loopback environment. rx_in is asynchronous to rxclk. rxclk runs at OVERSAMPLE times the baud rate, so one tick equals one rxclk cycle. The block adds majority-vote sampling, framing-error and overrun detection.

---
 rtl/uart_rx_oversample.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample
//   UART receive engine with an oversampled clock. rx_in passes through a
//   synchronizer. Each bit is decided by a majority vote of three samples
//   taken around the middle of the bit. One received byte is held until
//   uld_rx_data copies it to rx_data. The engine reports a low stop bit
//   (frame_err) and a byte lost because the holding register was still full
//   (overrun).
//
// Ports
//   rxclk        receive clock, OVERSAMPLE x baud rate
//   reset        asynchronous, active-low reset
//   rx_enable    receiver enable; 0 forces IDLE and drops any partial frame
//   rx_in        serial line, idle high, asynchronous to rxclk
//   uld_rx_data  unload strobe; copies the held byte to rx_data
//   rx_data      last unloaded byte
//   rx_empty     1 = no unread byte is held
//   rx_busy      1 = a frame is being received (state != IDLE)
//   frame_err    sticky; the stop bit was sampled low
//   overrun      sticky; a completed byte was dropped because the holding
//                register was full
module uart_rx_oversample #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 rxclk,
  input  logic                 reset,
  input  logic                 rx_enable,
  input  logic                 rx_in,
  input  logic                 uld_rx_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // The three vote samples sit at OVERSAMPLE/2-1, OVERSAMPLE/2 and
  // OVERSAMPLE/2+1. The vote is decided on the tick of the last sample.
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_empty_q, rx_empty_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic line;
  logic vote;
  logic unload;
  logic complete;
  logic set_fe;

  assign line   = sync_q[SYNC_STAGES-1];
  assign vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & line) | (samp_q[1] & line);
  assign unload = uld_rx_data & ~rx_empty_q;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first. A path
    // that skips an assignment would otherwise infer a latch.
    state_d     = state_q;
    sync_d      = {sync_q[SYNC_STAGES-2:0], rx_in};
    tick_d      = tick_q;
    bit_d       = bit_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    rx_data_d   = rx_data_q;
    rx_empty_d  = rx_empty_q;
    complete    = 1'b0;
    set_fe      = 1'b0;

    // Sample capture does not depend on state. Outside START/DATA/STOP the
    // captured values are never used.
    if (tick_q == TICK_S0) samp_d[0] = line;
    if (tick_q == TICK_S1) samp_d[1] = line;

    if (!rx_enable) begin
      // A partial frame is dropped silently. No flag is set.
      state_d = ST_IDLE;
      tick_d  = '0;
      bit_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tick_d = '0;
          bit_d  = '0;
          if (!line) state_d = ST_START;
        end
        ST_START: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_VOTE && vote) begin
            state_d = ST_IDLE;                 // false start (glitch)
            tick_d  = '0;
          end else if (tick_q == TICK_LAST) begin
            state_d = ST_DATA;
            tick_d  = '0;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_VOTE) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (bit_q == BIT_LAST) state_d = ST_STOP;
            else                   bit_d   = bit_q + BIT_W'(1);
          end
        end
        ST_STOP: begin
          tick_d = tick_q + TICK_W'(1);
          if (tick_q == TICK_VOTE) begin
            tick_d = '0;
            // Leaving at mid stop bit means the next start edge is accepted
            // up to half a bit early, which absorbs baud mismatch.
            if (vote) begin
              complete = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              set_fe  = 1'b1;
              state_d = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (line) state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end

    // Holding register. An unload and a completion can happen on the same
    // edge. In that case the old byte moves out, the new byte moves in, and
    // rx_empty stays 0.
    if (unload) begin
      rx_data_d  = hold_q;
      rx_empty_d = 1'b1;
    end
    if (complete && (rx_empty_q || unload)) begin
      hold_d     = shift_q;
      rx_empty_d = 1'b0;
    end

    // Sticky flags. Unload clears them. A set on the same edge wins.
    frame_err_d = (frame_err_q & ~uld_rx_data) | set_fe;
    overrun_d   = (overrun_q & ~uld_rx_data) | (complete & ~rx_empty_q & ~unload);
  end

  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      // The synchronizer resets to the idle line level. A reset release
      // therefore never looks like a start edge.
      sync_q      <= '1;
      tick_q      <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      rx_data_q   <= '0;
      rx_empty_q  <= 1'b1;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here mean every flop sees the values
      // from before the edge. That is independent of statement order.
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      rx_empty_q  <= rx_empty_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_empty  = rx_empty_q;
  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Testbench for uart_rx_oversample.
//   The bench drives serial frames onto rx_in one rxclk per tick.
//   Expected bytes are pushed into a scoreboard queue when a frame is sent.
//   They are popped and compared when the byte is unloaded.
//   A table of frames covers normal reception, including glitches.
//   Hand-written sequences cover:
//     - overrun
//     - false start
//     - framing error and break
//     - rx_enable drop
//     - reset during a frame
module tb_uart_rx_oversample;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          rxclk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_enable = 1'b1;
  logic          rx_in = 1'b1;
  logic          uld_rx_data = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_empty;
  logic          rx_busy;
  logic          frame_err;
  logic          overrun;

  uart_rx_oversample #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .rxclk      (rxclk),
    .reset      (reset),
    .rx_enable  (rx_enable),
    .rx_in      (rx_in),
    .uld_rx_data(uld_rx_data),
    .rx_data    (rx_data),
    .rx_empty   (rx_empty),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 rxclk = ~rxclk;

  int checks   = 0;
  int failures = 0;

  // Cycle counter and rx_empty fall detector, used for the latency check.
  int   cyc = 0;
  int   fall_cyc = -1;
  logic empty_prev = 1'b1;
  always @(posedge rxclk) cyc <= cyc + 1;
  always @(negedge rxclk) begin
    empty_prev <= rx_empty;
    if (empty_prev === 1'b1 && rx_empty === 1'b0) fall_cyc <= cyc;
  end

  logic [DB-1:0] exp_q[$];

  typedef struct {
    logic [DB-1:0] data;       // byte sent on the line
    int            glitch_bit; // data bit with a one-tick glitch mid-bit, -1 none
    logic [DB-1:0] exp_data;   // byte expected on rx_data after unload
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge rxclk);
    #1;
  endtask

  // One bit cell. An optional single-tick inversion at mid-bit.
  task automatic send_cell(input logic b, input logic glitch);
    for (int i = 0; i < OS; i++) begin
      rx_in = (glitch && i == OS / 2) ? ~b : b;
      step(1);
    end
  endtask

  // Start bit followed by the first nbits data bits, LSB first.
  task automatic send_bits(input logic [DB-1:0] data, input int nbits, input int glitch_bit);
    send_cell(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_cell(data[i], glitch_bit == i);
  endtask

  task automatic send_frame(input logic [DB-1:0] data);
    send_bits(data, DB, -1);
    send_cell(1'b1, 1'b0);
    rx_in = 1'b1;
  endtask

  // Wait for a held byte (bounded). Unload it and compare the byte against
  // the scoreboard.
  task automatic unload_check(input string name);
    int            n;
    logic [DB-1:0] exp;
    n = 0;
    while (rx_empty !== 1'b0 && n < 400) begin
      step(1);
      n++;
    end
    check({name, "_ready"}, rx_empty, 1'b0);
    if (rx_empty === 1'b0) begin
      uld_rx_data = 1'b1;
      step(1);
      uld_rx_data = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_scoreboard: got 0x%0h expected no byte", name, rx_data);
      end else begin
        exp = exp_q.pop_front();
        check({name, "_data"}, rx_data, exp);
      end
      check({name, "_empty_after"}, rx_empty, 1'b1);
    end
  endtask

  initial begin
    int start_cyc;

    vecs[0] = '{data: 8'h55, glitch_bit: -1, exp_data: 8'h55};
    vecs[1] = '{data: 8'hA3, glitch_bit: -1, exp_data: 8'hA3};
    vecs[2] = '{data: 8'h0F, glitch_bit: -1, exp_data: 8'h0F};
    vecs[3] = '{data: 8'hFF, glitch_bit:  3, exp_data: 8'hFF};
    vecs[4] = '{data: 8'h00, glitch_bit:  5, exp_data: 8'h00};
    vecs[5] = '{data: 8'h80, glitch_bit:  0, exp_data: 8'h80};

    // Reset state.
    step(3);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_empty", rx_empty, 1'b1);
    check("rst_rx_busy", rx_busy, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b1;
    step(4);

    // Table-driven frames, each unloaded immediately.
    foreach (vecs[k]) begin
      fall_cyc  = -1;
      start_cyc = cyc;
      send_bits(vecs[k].data, DB, vecs[k].glitch_bit);
      send_cell(1'b1, 1'b0);
      exp_q.push_back(vecs[k].exp_data);
      check_range($sformatf("latency_%0d", k), fall_cyc - start_cyc, 152, 160);
      unload_check($sformatf("vec_%0d", k));
      check($sformatf("vec_%0d_frame_err", k), frame_err, 1'b0);
      check($sformatf("vec_%0d_overrun", k), overrun, 1'b0);
      step(3);
    end

    // Overrun: 0x3C is left held, so 0xC3 is dropped.
    send_frame(8'h3C);
    exp_q.push_back(8'h3C);
    step(2);
    send_frame(8'hC3);
    step(2);
    check("ovr_set", overrun, 1'b1);
    check("ovr_empty", rx_empty, 1'b0);
    unload_check("ovr");
    check("ovr_cleared", overrun, 1'b0);
    step(3);

    // False start: rx_in is low for 4 ticks only.
    rx_in = 1'b0;
    step(4);
    rx_in = 1'b1;
    step(2);
    check("fs_busy_during", rx_busy, 1'b1);
    step(20);
    check("fs_busy_after", rx_busy, 1'b0);
    check("fs_empty", rx_empty, 1'b1);

    // Framing error. The stop bit is low and the line stays low for
    // 3 bit times in total.
    send_bits(8'h81, DB, -1);
    send_cell(1'b0, 1'b0);
    rx_in = 1'b0;
    step(2 * OS);
    check("fe_set", frame_err, 1'b1);
    check("fe_empty", rx_empty, 1'b1);
    check("fe_busy_break", rx_busy, 1'b1);
    rx_in = 1'b1;
    step(5);
    check("fe_busy_released", rx_busy, 1'b0);
    step(4);
    send_frame(8'h12);
    exp_q.push_back(8'h12);
    check("fe_sticky", frame_err, 1'b1);
    unload_check("fe_next");
    check("fe_cleared", frame_err, 1'b0);
    step(3);

    // rx_enable drops in the middle of 0x99. Outputs keep their values.
    send_bits(8'h99, 3, -1);
    check("en_busy_mid", rx_busy, 1'b1);
    rx_enable = 1'b0;
    rx_in     = 1'b1;
    step(2);
    check("en_busy_off", rx_busy, 1'b0);
    check("en_rx_data_kept", rx_data, 8'h12);
    check("en_empty_kept", rx_empty, 1'b1);
    check("en_fe_kept", frame_err, 1'b0);
    check("en_ovr_kept", overrun, 1'b0);
    step(2 * OS);
    rx_enable = 1'b1;
    step(3);
    check("en_no_ghost", rx_empty, 1'b1);
    send_frame(8'h66);
    exp_q.push_back(8'h66);
    unload_check("en_next");
    step(3);

    // Reset asserted in the middle of 0x99. All outputs return to reset values.
    send_bits(8'h99, 3, -1);
    reset = 1'b0;
    rx_in = 1'b1;
    step(1);
    check("mrst_rx_data", rx_data, 8'h00);
    check("mrst_rx_empty", rx_empty, 1'b1);
    check("mrst_rx_busy", rx_busy, 1'b0);
    check("mrst_frame_err", frame_err, 1'b0);
    check("mrst_overrun", overrun, 1'b0);
    reset = 1'b1;
    step(4);
    send_frame(8'h66);
    exp_q.push_back(8'h66);
    unload_check("mrst_next");

    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
